// File: rtl/muldiv_pkg.sv
// Shared opcode constants and FSM encodings for the HI/LO multiply/divide unit.
// The ALU control decoder imports the same code constants.
package muldiv_pkg;

  localparam int MD_DATA_W = 32;

  localparam logic [4:0] ALU_MULT = 5'b00101;
  localparam logic [4:0] ALU_DIV  = 5'b01011;
  localparam logic [4:0] ALU_MADD = 5'b01100;
  localparam logic [4:0] ALU_MSUB = 5'b01101;
  localparam logic [4:0] ALU_MFHI = 5'b10000;
  localparam logic [4:0] ALU_MTHI = 5'b10001;
  localparam logic [4:0] ALU_MFLO = 5'b10010;
  localparam logic [4:0] ALU_MTLO = 5'b10011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  function automatic logic is_mul_op(input logic [4:0] ctl);
    return (ctl == ALU_MULT) || (ctl == ALU_MADD) || (ctl == ALU_MSUB);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Combinational radix-2 step (shift-add multiply / restoring divide) and the
// final sign fix that produces the new {HI,LO} value.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int DATA_W = MD_DATA_W
) (
  input  logic [4:0]          i_op,
  input  logic [2*DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0]   i_opnd,
  input  logic                i_neg_a,
  input  logic                i_neg_b,
  input  logic [DATA_W-1:0]   i_hi,
  input  logic [DATA_W-1:0]   i_lo,
  output logic [2*DATA_W-1:0] o_acc_next,
  output logic [DATA_W-1:0]   o_hi_fix,
  output logic [DATA_W-1:0]   o_lo_fix
);

  logic                w_is_div;
  logic [DATA_W:0]     w_mul_sum;
  logic [DATA_W:0]     w_trial;
  logic                w_q_bit;
  logic [DATA_W-1:0]   w_rem_next;
  logic                w_neg_res;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_quo;
  logic [DATA_W-1:0]   w_rem;
  logic [2*DATA_W-1:0] w_res;

  assign w_is_div = (i_op == ALU_DIV);

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign w_mul_sum = {1'b0, i_acc[2*DATA_W-1:DATA_W]} + {1'b0, {DATA_W{i_acc[0]}} & i_opnd};

  // Divide: acc = {remainder, dividend bits becoming quotient bits}, shifted left each step.
  assign w_trial    = i_acc[2*DATA_W-1:DATA_W-1] - {1'b0, i_opnd};
  assign w_q_bit    = ~w_trial[DATA_W];
  assign w_rem_next = w_q_bit ? w_trial[DATA_W-1:0] : i_acc[2*DATA_W-2:DATA_W-1];

  assign o_acc_next = w_is_div ? {w_rem_next, i_acc[DATA_W-2:0], w_q_bit}
                               : {w_mul_sum, i_acc[DATA_W-1:1]};

  assign w_neg_res = i_neg_a ^ i_neg_b;
  assign w_prod    = w_neg_res ? -i_acc : i_acc;
  assign w_quo     = w_neg_res ? -i_acc[DATA_W-1:0] : i_acc[DATA_W-1:0];
  assign w_rem     = i_neg_a ? -i_acc[2*DATA_W-1:DATA_W] : i_acc[2*DATA_W-1:DATA_W];

  always_comb begin
    w_res = w_prod;
    case (i_op)
      ALU_MADD: w_res = {i_hi, i_lo} + w_prod;
      ALU_MSUB: w_res = {i_hi, i_lo} - w_prod;
      ALU_DIV:  w_res = {w_rem, w_quo};
      default:  w_res = w_prod;
    endcase
  end

  assign o_hi_fix = w_res[2*DATA_W-1:DATA_W];
  assign o_lo_fix = w_res[DATA_W-1:0];

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// FSM IDLE -> CALC (DATA_W steps) -> FIX; Busy stalls dependents, Done pulses on write.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = MD_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [4:0]        i_alu_ctl,
  input  logic              i_unsigned,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_result,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  localparam int CW = $clog2(DATA_W);

  logic [1:0]          r_state;
  logic [CW-1:0]       r_cnt;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_done;
  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_opnd;
  logic [4:0]          r_op;
  logic                r_neg_a;
  logic                r_neg_b;

  logic                w_neg_a;
  logic                w_neg_b;
  logic [DATA_W-1:0]   w_mag_a;
  logic [DATA_W-1:0]   w_mag_b;
  logic [2*DATA_W-1:0] w_acc_next;
  logic [DATA_W-1:0]   w_hi_fix;
  logic [DATA_W-1:0]   w_lo_fix;

  assign w_neg_a = ~i_unsigned & i_a[DATA_W-1];
  assign w_neg_b = ~i_unsigned & i_b[DATA_W-1];
  assign w_mag_a = w_neg_a ? -i_a : i_a;
  assign w_mag_b = w_neg_b ? -i_b : i_b;

  muldiv_datapath #(.DATA_W(DATA_W)) u_datapath (
    .i_op       (r_op),
    .i_acc      (r_acc),
    .i_opnd     (r_opnd),
    .i_neg_a    (r_neg_a),
    .i_neg_b    (r_neg_b),
    .i_hi       (r_hi),
    .i_lo       (r_lo),
    .o_acc_next (w_acc_next),
    .o_hi_fix   (w_hi_fix),
    .o_lo_fix   (w_lo_fix)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_op    <= '0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (is_mul_op(i_alu_ctl)) begin
              r_op    <= i_alu_ctl;
              r_acc   <= {{DATA_W{1'b0}}, w_mag_b};
              r_opnd  <= w_mag_a;
              r_neg_a <= w_neg_a;
              r_neg_b <= w_neg_b;
              r_cnt   <= '0;
              r_state <= ST_CALC;
            end else if (i_alu_ctl == ALU_DIV) begin
              // Divide by zero short-circuits: no iteration, immediate write.
              if (i_b == '0) begin
                r_hi   <= i_a;
                r_lo   <= '1;
                r_done <= 1'b1;
              end else begin
                r_op    <= i_alu_ctl;
                r_acc   <= {{DATA_W{1'b0}}, w_mag_a};
                r_opnd  <= w_mag_b;
                r_neg_a <= w_neg_a;
                r_neg_b <= w_neg_b;
                r_cnt   <= '0;
                r_state <= ST_CALC;
              end
            end else if (i_alu_ctl == ALU_MTHI) begin
              r_hi <= i_a;
            end else if (i_alu_ctl == ALU_MTLO) begin
              r_lo <= i_a;
            end
          end
        end
        ST_CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(DATA_W - 1)) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          r_hi    <= w_hi_fix;
          r_lo    <= w_lo_fix;
          r_done  <= 1'b1;
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_result = '0;
    if (i_alu_ctl == ALU_MFHI) begin
      o_result = r_hi;
    end else if (i_alu_ctl == ALU_MFLO) begin
      o_result = r_lo;
    end
  end

  assign o_busy = (r_state != ST_IDLE);
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomized bench for hilo_muldiv_unit against a countdown-plus-arithmetic model,
// with literal expectations for the hand-worked cases.
module tb_hilo_muldiv_unit;
  import muldiv_pkg::*;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [4:0]        ctl = 5'b0;
  logic              uns = 1'b0;
  logic [31:0]       opa = '0;
  logic [31:0]       opb = '0;
  logic              busy, done;
  logic [31:0]       result, hi, lo;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  hilo_muldiv_unit #(.DATA_W(DATA_W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_alu_ctl  (ctl),
    .i_unsigned (uns),
    .i_a        (opa),
    .i_b        (opb),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result),
    .o_hi       (hi),
    .o_lo       (lo)
  );

  always #5 clk = ~clk;

  // Reference: the architectural answer computed with plain 64-bit arithmetic.
  function automatic logic [63:0] ref_calc(input logic [4:0] c, input logic u,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] h, input logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = u ? longint'({32'b0, a}) : longint'($signed(a));
    sb = u ? longint'({32'b0, b}) : longint'($signed(b));
    p = 64'(sa * sb);
    if (c == ALU_DIV) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    if (c == ALU_MADD) return {h, l} + p;
    if (c == ALU_MSUB) return {h, l} - p;
    return p;
  endfunction

  logic [31:0] m_hi, m_lo;
  logic        m_done;
  int          m_rem;
  logic [63:0] m_pend;

  // Model: a long op is busy for DATA_W+1 edges, then writes its answer with a Done pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_rem <= 0; m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_hi <= m_pend[63:32];
          m_lo <= m_pend[31:0];
          m_done <= 1'b1;
        end
      end else if (start) begin
        if (ctl == ALU_MULT || ctl == ALU_MADD || ctl == ALU_MSUB ||
            (ctl == ALU_DIV && opb != 0)) begin
          m_pend <= ref_calc(ctl, uns, opa, opb, m_hi, m_lo);
          m_rem <= DATA_W + 1;
        end else if (ctl == ALU_DIV) begin
          m_hi <= opa; m_lo <= '1; m_done <= 1'b1;
        end else if (ctl == ALU_MTHI) begin
          m_hi <= opa;
        end else if (ctl == ALU_MTLO) begin
          m_lo <= opa;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", 64'(busy), 64'(m_rem != 0));
      chk("done", 64'(done), 64'(m_done));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
      if (m_rem == 0)
        chk("result", 64'(result),
            64'((ctl == ALU_MFHI) ? m_hi : (ctl == ALU_MFLO) ? m_lo : 32'h0));
    end
  end

  task automatic drive(input logic [4:0] c, input logic u, input logic [31:0] a,
                       input logic [31:0] b);
    start = 1'b1; ctl = c; uns = u; opa = a; opb = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_long();
    repeat (DATA_W + 1) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [4:0] codes [10] = '{ALU_MULT, ALU_DIV, ALU_MADD, ALU_MSUB, ALU_MFHI,
                             ALU_MTHI, ALU_MFLO, ALU_MTLO, 5'b00000, 5'b11111};

  initial begin
    logic [4:0] c;
    logic       is_long;
    int         k;

    repeat (2) @(posedge clk);
    check_en = 1'b1;
    #1;
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    drive(ALU_MULT, 1'b0, 32'hFFFF_FFFD, 32'd7);
    chk("mult_busy_c1", 64'(busy), 64'h1);
    wait_long();
    chk("mult_done", 64'(done), 64'h1);
    chk("mult_busy_end", 64'(busy), 64'h0);
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);
    @(posedge clk); #1;
    chk("mult_done_1cyc", 64'(done), 64'h0);

    drive(ALU_DIV, 1'b1, 32'd100, 32'd7);
    wait_long();
    chk("divu_lo", 64'(lo), 64'd14);
    chk("divu_hi", 64'(hi), 64'd2);
    drive(ALU_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2);
    wait_long();
    chk("divs_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("divs_hi", 64'(hi), 64'hFFFF_FFFF);
    drive(ALU_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_long();
    chk("ovf_lo", 64'(lo), 64'h8000_0000);
    chk("ovf_hi", 64'(hi), 64'h0);

    drive(ALU_MTLO, 1'b0, 32'd5, 32'd0);
    drive(ALU_MTHI, 1'b0, 32'd0, 32'd0);
    drive(ALU_MADD, 1'b0, 32'd2, 32'd3);
    wait_long();
    chk("madd_hi", 64'(hi), 64'h0);
    chk("madd_lo", 64'(lo), 64'd11);
    drive(ALU_MSUB, 1'b0, 32'd4, 32'd4);
    wait_long();
    chk("msub_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("msub_lo", 64'(lo), 64'hFFFF_FFFB);

    drive(ALU_DIV, 1'b0, 32'h1234, 32'h0);
    chk("dz_hi", 64'(hi), 64'h1234);
    chk("dz_lo", 64'(lo), 64'hFFFF_FFFF);
    chk("dz_done", 64'(done), 64'h1);
    chk("dz_busy", 64'(busy), 64'h0);

    drive(ALU_MULT, 1'b1, 32'h1234_5678, 32'h100);
    repeat (4) @(posedge clk);
    #1 drive(ALU_MTHI, 1'b0, 32'd9, 32'd0);
    repeat (DATA_W - 4) @(posedge clk);
    #1;
    chk("haz_done", 64'(done), 64'h1);
    chk("haz_hi", 64'(hi), 64'h12);
    chk("haz_lo", 64'(lo), 64'h3456_7800);
    ctl = ALU_MFHI;
    #1 chk("haz_mfhi", 64'(result), 64'h12);

    drive(ALU_DIV, 1'b1, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_done", 64'(done), 64'h0);
    chk("arst_hi", 64'(hi), 64'h0);
    chk("arst_lo", 64'(lo), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(ALU_MULT, 1'b0, 32'd6, 32'd7);
    wait_long();
    chk("post_rst_done", 64'(done), 64'h1);
    chk("post_rst_lo", 64'(lo), 64'd42);

    for (int i = 0; i < 150; i++) begin
      c = codes[$urandom_range(0, 9)];
      drive(c, 1'($urandom_range(0, 1)), pick_opnd(), pick_opnd());
      is_long = (c == ALU_MULT || c == ALU_MADD || c == ALU_MSUB ||
                 (c == ALU_DIV && opb != 0));
      if (is_long) begin
        if ($urandom_range(0, 3) == 0) begin
          k = $urandom_range(1, 20);
          repeat (k) @(posedge clk);
          #1 drive(codes[$urandom_range(0, 9)], 1'b0, $urandom, $urandom);
          repeat (DATA_W - k) @(posedge clk);
          #1;
        end else begin
          wait_long();
        end
      end
      ctl = ($urandom_range(0, 1) == 1) ? ALU_MFHI : ALU_MFLO;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the ALU control decoder.
- It consumes the 5-bit ALU control code for mult, div, madd, msub, mfhi, mthi, mflo and mtlo, plus the EX-stage operands.
- It runs iterative shift-add multiply and restoring divide.
- It raises Busy so the pipeline hazard logic can stall dependent instructions.

Parameters:
- DATA_W, 32, operand width. The iteration count equals DATA_W.

Ports:
- Clk  in  1  single clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- Start  in  1  EX-stage op valid this cycle
- ALUCtl  in  5  operation code from the ALU control decoder
- Unsigned  in  1  1 = multu/divu semantics, 0 = signed
- A  in  DATA_W  rs operand (multiplicand/dividend)
- B  in  DATA_W  rt operand (multiplier/divisor)
- Busy  out  1  iterative op in flight; stall request
- Done  out  1  one-cycle pulse when HI/LO update from mul/div
- Result  out  DATA_W  HI for mfhi, LO for mflo, else 0
- HI  out  DATA_W  HI register
- LO  out  DATA_W  LO register

Behaviour:
- Interface: one clock (Clk); reset Rst_n is asynchronous and active-low.
- Reset values: HI=0, LO=0, Busy=0, Done=0, state IDLE, iteration counter 0. Reset asserted mid-operation aborts immediately; HI/LO are not written.
- Codes: mult=00101, div=01011, madd=01100, msub=01101, mfhi=10000, mthi=10001, mflo=10010, mtlo=10011. Start with any other code is ignored.
- States: IDLE, CALC, FIX.
- IDLE:
  - Start with mult/madd/msub/div: latch operand magnitudes (abs if signed), latch result sign, clear accumulator, go to CALC with counter=0, Busy=1.
  - Start with mthi: HI<=A at the next edge. Start with mtlo: LO<=A. No Done pulse for either.
  - div with B==0: no CALC. HI<=A, LO<=all-ones at the next edge, Done pulses, Busy stays 0.
- CALC: one radix-2 iteration per cycle for DATA_W cycles. Mul is a 2*DATA_W-bit shift-add. Div is a restoring quotient/remainder step. When counter reaches DATA_W-1, go to FIX.
- FIX, one cycle, then back to IDLE with Done=1 for exactly one cycle:
  - Apply signs. The signed product is negated if operand signs differ. The quotient is negated if operand signs differ. The remainder takes the dividend's sign.
  - Write HI/LO as follows. mult: {HI,LO}=product. madd: {HI,LO}+=product. msub: {HI,LO}-=product. Both madd and msub are 64-bit modulo. div: LO=quotient, HI=remainder.
- Latency: Start sampled at edge 0. Busy=1 after edges 0..DATA_W. HI/LO are written and Done=1 after edge DATA_W+1, which is 33 cycles for DATA_W=32. Busy is low in that same cycle.
- Start while Busy=1 is ignored, including mthi/mtlo. The upstream stall logic guarantees none occurs.
- Result: combinational. Result=HI when ALUCtl=mfhi, LO when ALUCtl=mflo, else 0. While Busy=1, Result is undefined and the consumer stalls.
- Signed overflow: -2^31 / -1 gives LO=0x80000000, HI=0. This is wrap behaviour with no trap.
- Unsigned=1: no abs/negate. madd/msub treat the product as unsigned.
- Done and an mthi/mtlo in the same cycle cannot occur, because Start is blocked by Busy until FIX completes.

Decomposition:
- Package muldiv_pkg: 5-bit ALUCtl localparams for the eight codes above; state enum IDLE/CALC/FIX; DATA_W default.
- The same code constants are shared with the ALU control decoder package.
- One natural sub-module, muldiv_datapath. It holds the shift-add/restoring-divide step logic and the sign fix. The FSM, counter and HI/LO registers stay in the top.

Test Plan:
- Signed mult: A=-3 (FFFFFFFD), B=7, Unsigned=0 -> after 33 cycles HI=FFFFFFFF, LO=FFFFFFEB, Done pulse one cycle; Busy high for cycles 1-32.
- Unsigned div: A=100, B=7, Unsigned=1 -> LO=14, HI=2. Signed div A=-7, B=2 -> LO=FFFFFFFD, HI=FFFFFFFF.
- Accumulate: mtlo 5, mthi 0, madd A=2 B=3 -> HI=0, LO=11. Then msub A=4 B=4 -> HI=FFFFFFFF, LO=FFFFFFFB.
- Div by zero: A=0x1234, B=0 -> next edge HI=0x1234, LO=FFFFFFFF, Done=1, Busy never asserts.
- Hazard: Start mult, then Start mthi A=9 at cycle 5 -> mthi ignored, final HI equals the product high word. mfhi after Done returns that HI.
- Reset: deassert Rst_n asynchronously at cycle 10 of a div -> HI=LO=0, Busy=0, Done=0 immediately. The next mult completes normally in 33 cycles.
